// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
// The optional hold-state timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_pkg;

   // Width of one transmitted character.
   localparam int UART_DATA_W = 8;

   // Arbiter sequencing states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      HOLD      = 3'd4
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first set bit of
// req scanning upward from ptr with wrap-around; ptr itself has top priority.
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // Scan offsets from the far end down so the nearest request wins last.
   always_comb begin
      int j;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (req[j]) begin
            idx = j[IDX_W-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte streams with
// packet-granular round-robin. An owner keeps the transmitter until it sends a
// byte flagged last, so messages never interleave.
// Optional: define UART_ARB_TIMEOUT_EN to release a stalled owner after
// TIMEOUT_CYCLES idle cycles in HOLD and raise the sticky timeout_flag.
//
// Handshake: a requester holds req_valid/req_data/req_last until it sees a
// one-cycle req_ready pulse; the byte is consumed in exactly that cycle.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           uart_start,
   output logic [UART_DATA_W-1:0]         uart_tx_data,
   input  logic                           uart_tx_busy,
   input  logic                           uart_tx_done,
   output logic                           grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                           timeout_flag
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   // Reject configurations the arbiter is not built for.
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   arb_state_e       state;
   logic [IDX_W-1:0] rr_ptr;
   logic             last_flag;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [IDX_W-1:0] next_ptr;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req (req_valid),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Pointer moves one past the owner that just finished, wrapping at NUM_REQ.
   always_comb begin
      next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] hold_cnt;
`endif

   // Arbitration and transmitter sequencing; start and ready are one-cycle pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         req_ready    <= '0;
         uart_start   <= 1'b0;
         uart_tx_data <= '0;
         grant_valid  <= 1'b0;
         grant_id     <= '0;
         rr_ptr       <= '0;
         last_flag    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         hold_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         req_ready  <= '0;
         uart_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_id    <= pick_idx;
                  grant_valid <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               // Only issue into an idle transmitter with the owner's byte present.
               if (!uart_tx_busy && req_valid[grant_id]) begin
                  uart_start   <= 1'b1;
                  uart_tx_data <= req_data[int'(grant_id)*UART_DATA_W +: UART_DATA_W];
                  req_ready    <= ONE_HOT0 << grant_id;
                  last_flag    <= req_last[grant_id];
                  state        <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (uart_tx_busy) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (uart_tx_done) begin
                  if (last_flag) begin
                     grant_valid <= 1'b0;
                     rr_ptr      <= next_ptr;
                     state       <= IDLE;
                  end else begin
                     state <= HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                     hold_cnt <= '0;
`endif
                  end
               end
            end
            HOLD: begin
               if (req_valid[grant_id]) begin
                  state <= LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
               end else if (hold_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  grant_valid  <= 1'b0;
                  rr_ptr       <= next_ptr;
                  timeout_flag <= 1'b1;
                  state        <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
// Requester and transmitter models run on the falling edge; the monitor pops
// the expected queue on every uart_start. Define UART_ARB_TIMEOUT_EN to also
// exercise the hold timeout.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int TX_LEN  = 6;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ*8-1:0] req_data = '0;
   logic [NUM_REQ-1:0]   req_last = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_start;
   logic [7:0]           uart_tx_data;
   logic                 uart_tx_busy = 1'b0;
   logic                 uart_tx_done = 1'b0;
   logic                 grant_valid;
   logic [IDX_W-1:0]     grant_id;
`ifdef UART_ARB_TIMEOUT_EN
   logic                 timeout_flag;
`endif

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(100)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .uart_start   (uart_start),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_done (uart_tx_done),
      .grant_valid  (grant_valid),
`ifdef UART_ARB_TIMEOUT_EN
      .grant_id     (grant_id),
      .timeout_flag (timeout_flag)
`else
      .grant_id     (grant_id)
`endif
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks    = 0;
   int n_fail      = 0;
   int start_count = 0;
   logic force_busy = 1'b0;

   logic [8:0] src_q [NUM_REQ][$];   // {last, data} per requester
   logic [9:0] exp_q [$];            // {grant_id, data} in transmit order

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Requester model: pop on ready, present the next queued byte.
   always @(negedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   end

   // Transmitter model: busy one cycle after start, done pulse TX_LEN later.
   int   tx_cnt = 0;
   logic busy_m = 1'b0;
   always @(negedge clk) begin
      uart_tx_done = 1'b0;
      if (reset) begin
         tx_cnt = 0;
         busy_m = 1'b0;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) begin
            busy_m       = 1'b0;
            uart_tx_done = 1'b1;
         end
      end else if (uart_start) begin
         busy_m = 1'b1;
         tx_cnt = TX_LEN;
      end
      uart_tx_busy = busy_m | force_busy;
   end

   // Monitor: every start must match the head of the expected queue.
   always @(negedge clk) begin
      logic [9:0] e;
      if (uart_start) begin
         start_count++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_start: data 0x%0h id %0d, required no start", uart_tx_data, grant_id);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(uart_tx_data), 32'(e[7:0]));
            check("grant_id_at_start", 32'(grant_id), 32'(e[9:8]));
            check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << e[9:8]));
            check("grant_valid_at_start", 32'(grant_valid), 32'd1);
         end
      end else if (req_ready != '0) begin
         check("req_ready_without_start", 32'(req_ready), 32'd0);
      end
   end

   // Driver tasks
   task automatic load(input int id, input logic [7:0] d, input logic last);
      src_q[id].push_back({last, d});
   endtask

   task automatic expect_tx(input logic [1:0] id, input logic [7:0] d);
      exp_q.push_back({id, d});
   endtask

   task automatic do_reset();
      @(posedge clk); #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_uart_start"}, 32'(uart_start), 32'd0);
      check({tag, "_uart_tx_data"}, 32'(uart_tx_data), 32'd0);
      check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
      check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      int pend;
      forever begin
         @(negedge clk);
         pend = 0;
         for (int i = 0; i < NUM_REQ; i++) pend += src_q[i].size();
         if ((pend == 0 && exp_q.size() == 0 && !grant_valid && !uart_tx_busy) || k >= budget) break;
         k++;
      end
      if (k >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
      end
      check({name, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_starts(input string name, input int target, input int budget);
      int k = 0;
      while (start_count < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      check({name, "_start_count"}, 32'(start_count), 32'(target));
   endtask

   // Directed test sequence
   initial begin
      int sc;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Single one-byte packet from requester 0
      load(0, 8'hA5, 1'b1);
      expect_tx(2'd0, 8'hA5);
      wait_idle("single", 200);

      // rr_ptr is now 1: requester 1 beats requester 0
      load(0, 8'h01, 1'b1);
      load(1, 8'h02, 1'b1);
      expect_tx(2'd1, 8'h02);
      expect_tx(2'd0, 8'h01);
      wait_idle("rr_after_single", 300);

      // Contention from rr_ptr 0
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) load(i, 8'h10 + 8'(i), 1'b1);
      for (int i = 0; i < NUM_REQ; i++) expect_tx(2'(i), 8'h10 + 8'(i));
      wait_idle("contention", 500);

      // Packet lock: requester 0 keeps the grant for three bytes
      do_reset();
      load(0, 8'h41, 1'b0);
      load(0, 8'h42, 1'b0);
      load(0, 8'h43, 1'b1);
      load(1, 8'h55, 1'b1);
      expect_tx(2'd0, 8'h41);
      expect_tx(2'd0, 8'h42);
      expect_tx(2'd0, 8'h43);
      expect_tx(2'd1, 8'h55);
      wait_idle("packet_lock", 500);

      // Busy guard: transmitter busy while the arbiter sits in LAUNCH
      force_busy = 1'b1;
      sc = start_count;
      load(2, 8'h66, 1'b1);
      expect_tx(2'd2, 8'h66);
      repeat (50) @(negedge clk);
      check("busy_no_start", 32'(start_count), 32'(sc));
      check("busy_grant_valid", 32'(grant_valid), 32'd1);
      check("busy_grant_id", 32'(grant_id), 32'd2);
      force_busy = 1'b0;
      wait_idle("busy_guard", 200);
      check("busy_one_start", 32'(start_count), 32'(sc + 1));

      // Reset during WAIT_DONE of byte 2 of 3
      sc = start_count;
      load(0, 8'h81, 1'b0);
      load(0, 8'h82, 1'b0);
      load(0, 8'h83, 1'b1);
      load(1, 8'h77, 1'b1);
      expect_tx(2'd0, 8'h81);
      expect_tx(2'd0, 8'h82);
      wait_starts("midreset_pre", sc + 2, 300);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      src_q[0].delete();
      exp_q.delete();
      expect_tx(2'd1, 8'h77);
      #1 check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      wait_idle("midreset_post", 200);

`ifdef UART_ARB_TIMEOUT_EN
      // Owner stalls in HOLD; grant released on the 100th HOLD cycle
      do_reset();
      sc = start_count;
      load(0, 8'h31, 1'b0);
      load(2, 8'h32, 1'b1);
      expect_tx(2'd0, 8'h31);
      expect_tx(2'd2, 8'h32);
      wait_starts("timeout_first", sc + 1, 100);
      begin
         int k = 0;
         while (!uart_tx_done && k < 100) begin
            @(posedge clk);
            k++;
         end
      end
      repeat (100) @(negedge clk);
      check("timeout_held_grant_valid", 32'(grant_valid), 32'd1);
      check("timeout_held_grant_id", 32'(grant_id), 32'd0);
      check("timeout_flag_before", 32'(timeout_flag), 32'd0);
      @(negedge clk);
      check("timeout_released", 32'(grant_valid), 32'd0);
      check("timeout_flag_set", 32'(timeout_flag), 32'd1);
      wait_idle("timeout_next", 300);
      check("timeout_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters (e.g. console, debug dump, status reporter).
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged last, so messages never interleave.
- Drives the transmitter's start/tx_data and sequences on its tx_busy/tx_done; sits between client logic and the uart top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1_000_000, hold-state idle limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of its packet.
- req_ready  output  NUM_REQ  one-cycle byte-consumed pulse, one-hot.
- uart_start  output  1  one-cycle start pulse to the transmitter.
- uart_tx_data  output  8  byte to the transmitter, stable from the start cycle until done.
- uart_tx_busy  input  1  transmitter busy.
- uart_tx_done  input  1  transmitter one-cycle done pulse.
- grant_valid  output  1  a requester currently owns the transmitter.
- grant_id  output  $clog2(NUM_REQ)  owner index; valid when grant_valid=1.

Behaviour:
- Reset: state IDLE; req_ready=0, uart_start=0, uart_tx_data=0, grant_valid=0, grant_id=0, rr pointer=0, last flag=0. Reset mid-transfer drops ownership immediately; the in-flight byte is not retried.
- Requester handshake: valid/data/last are held until req_ready is seen. A byte is consumed only in the cycle req_ready[i]=1.
- States:
  - IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward with wrap (index rr_ptr has highest priority). Register grant_id and set grant_valid. Go to LAUNCH. With no request, stay.
  - LAUNCH: entered only when uart_tx_busy=0; otherwise wait here.
    - In the issuing cycle: uart_start=1, latch uart_tx_data=req_data[grant_id], req_ready[grant_id]=1, latch last flag=req_last[grant_id].
    - Go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart_tx_busy=1 (one cycle after start), then go to WAIT_DONE.
  - WAIT_DONE: wait for uart_tx_done=1.
    - If last flag=1: grant_valid=0, rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: the owner keeps the grant. When req_valid[grant_id]=1, go to LAUNCH. Other requesters are ignored.
- Latency: the IDLE request cycle produces uart_start two cycles later (IDLE→LAUNCH, start asserted in LAUNCH). After tx_done on a non-last byte, the next start comes at least 2 cycles later.
- Boundaries:
  - Simultaneous requests: resolved strictly by rr_ptr.
  - Wrap: the scan wraps from NUM_REQ-1 to 0.
  - Owner drops req_valid in HOLD: wait indefinitely (without the option below).
  - Single-byte packet (last=1 on the first byte): behaves as a one-byte grant.
  - req_ready is never asserted for a non-owner, and never twice per start.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in HOLD and is cleared on entry.
  - If it reaches TIMEOUT_CYCLES-1 with req_valid[grant_id]=0, the grant is released: grant_valid=0, rr_ptr=grant_id+1, go to IDLE.
  - A sticky output timeout_flag (1 bit, reset 0, cleared by reset only) is set.
- UART_ARB_TIMEOUT_EN undefined: no counter and no timeout_flag port; HOLD waits forever.

Decomposition:
- Package uart_pkg:
  - arb_state_e enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD}.
  - Constant UART_DATA_W=8.
- Sub-module rr_picker (NUM_REQ param): combinational round-robin first-one-from-pointer selector. Outputs idx and any.

Test Plan:
- Single request: req_valid=4'b0001, data 8'hA5, last=1 → one uart_start, uart_tx_data=8'hA5, req_ready[0] pulse; grant_valid drops after tx_done; rr_ptr=1.
- Contention: all four valid, single-byte packets, data 8'h10..8'h13 → grants 0,1,2,3 in order; transmitted bytes 10,11,12,13.
- Packet lock: req0 sends 3 bytes 8'h41,8'h42,8'h43 (last on the third) while req1 is valid with 8'h55 → output sequence 41,42,43,55; grant_id stays 0 across the three bytes.
- Busy guard: uart_tx_busy forced high in LAUNCH for 50 cycles → no uart_start until it falls, then exactly one start.
- Reset mid-packet: assert reset during WAIT_DONE of byte 2 of 3 → all outputs 0 at once; after release, req1 (8'h77) is granted first, with rr_ptr=0 and req0 idle.
- UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100: owner stalls in HOLD → release at cycle 100, timeout_flag=1, pending req2 granted next.
